// File: rtl/wb_data_ram_if.sv
// Pipelined Wishbone B4 data-bus bundle between the core memory stage and wb_data_ram.
// Names follow the core side: wb_odata flows into the RAM, wb_idata flows back out.
interface wb_data_ram_if;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [29:0] wb_addr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_odata;
   logic [31:0] wb_idata;
   logic        wb_ack;
   logic        wb_err;
   logic        wb_stall;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_odata,
      input  wb_idata, wb_ack, wb_err, wb_stall
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_odata,
      output wb_idata, wb_ack, wb_err, wb_stall
   );
endinterface

// File: rtl/wb_data_ram.sv
// Pipelined Wishbone B4 data RAM: byte-lane writes at acceptance, fixed-latency in-order
// ack/err responses, and a pending counter that throttles the bus through wb_stall.
module wb_data_ram #(
   parameter int DEPTH       = 4096,
   parameter int LATENCY     = 2,
   parameter int MAX_PENDING = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   wb_data_ram_if.slave bus
);
   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            PW       = $clog2(MAX_PENDING + 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          resp;
   logic [PW-1:0] pending;

   logic          vld_p  [LATENCY];
   logic          err_p  [LATENCY];
   logic [31:0]   data_p [LATENCY];

   function automatic logic [PW-1:0] pending_next(input logic [PW-1:0] cur,
                                                  input logic          inc,
                                                  input logic          dec);
      logic [PW-1:0] nxt;
      nxt = cur;
      if (inc && !dec && cur != PEND_MAX)
         nxt = cur + PW'(1);
      else if (dec && !inc && cur != '0)
         nxt = cur - PW'(1);
      return nxt;
   endfunction

   assign idx      = bus.wb_addr[AW-1:0];
   assign in_range = {2'b00, bus.wb_addr} < 32'(DEPTH);
   assign accept   = bus.wb_cyc && bus.wb_stb && !bus.wb_stall && !i_reset;
   assign resp     = bus.wb_ack || bus.wb_err;

   // Response taps: last pipeline stage, qualified by the live bus cycle.
   assign bus.wb_ack   = vld_p[LATENCY-1] && !err_p[LATENCY-1] && bus.wb_cyc;
   assign bus.wb_err   = vld_p[LATENCY-1] &&  err_p[LATENCY-1] && bus.wb_cyc;
   assign bus.wb_idata = bus.wb_ack ? data_p[LATENCY-1] : 32'h0;
   assign bus.wb_stall = (pending == PEND_MAX) && !bus.wb_ack && !bus.wb_err;

   // Stage 0 is loaded at the acceptance edge; later stages shift every cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset || !bus.wb_cyc) begin
         for (int s = 0; s < LATENCY; s++)
            vld_p[s] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int s = 1; s < LATENCY; s++)
            vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || !bus.wb_cyc)
         pending <= '0;
      else
         pending <= pending_next(pending, accept, resp);
   end

   // Read data is the pre-write word; the write lands in the same edge and is seen next edge.
   always_ff @(posedge i_clk) begin
      if (accept && in_range && bus.wb_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.wb_sel[b])
               mem[idx][8*b +: 8] <= bus.wb_odata[8*b +: 8];
      end
      data_p[0] <= mem[idx];
      err_p[0]  <= !in_range;
      for (int s = 1; s < LATENCY; s++) begin
         data_p[s] <= data_p[s-1];
         err_p[s]  <= err_p[s-1];
      end
   end
endmodule

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: one instance at LATENCY=2/MAX_PENDING=2 and one at
// LATENCY=4/MAX_PENDING=2 for throttling.
module tb_wb_data_ram;
   logic i_clk = 1'b0;
   logic i_reset;
   int   tests = 0;
   int   fails = 0;

   always #5 i_clk = ~i_clk;

   wb_data_ram_if bus_a();
   wb_data_ram_if bus_b();

   wb_data_ram #(.DEPTH(4096), .LATENCY(2), .MAX_PENDING(2)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .bus(bus_a.slave)
   );
   wb_data_ram #(.DEPTH(4096), .LATENCY(4), .MAX_PENDING(2)) u_thr (
      .i_clk(i_clk), .i_reset(i_reset), .bus(bus_b.slave)
   );

   logic        oa_ack, oa_err, oa_stall;
   logic [31:0] oa_data;
   int          oa_pend;
   logic        ob_ack, ob_err, ob_stall;
   logic [31:0] ob_data;
   int          ob_pend;

   // Drive one cycle on bus A, sample at the falling edge, return just after the rising edge.
   task automatic step_a(input logic rst, input logic cyc, input logic stb, input logic we,
                         input logic [29:0] addr, input logic [3:0] sel, input logic [31:0] wd);
      i_reset = rst;
      bus_a.wb_cyc = cyc; bus_a.wb_stb = stb; bus_a.wb_we = we;
      bus_a.wb_addr = addr; bus_a.wb_sel = sel; bus_a.wb_odata = wd;
      @(negedge i_clk);
      oa_ack = bus_a.wb_ack; oa_err = bus_a.wb_err; oa_stall = bus_a.wb_stall;
      oa_data = bus_a.wb_idata; oa_pend = int'(u_dut.pending);
      @(posedge i_clk); #1;
   endtask

   task automatic step_b(input logic cyc, input logic stb, input logic we,
                         input logic [29:0] addr, input logic [31:0] wd);
      i_reset = 1'b0;
      bus_b.wb_cyc = cyc; bus_b.wb_stb = stb; bus_b.wb_we = we;
      bus_b.wb_addr = addr; bus_b.wb_sel = 4'hF; bus_b.wb_odata = wd;
      @(negedge i_clk);
      ob_ack = bus_b.wb_ack; ob_err = bus_b.wb_err; ob_stall = bus_b.wb_stall;
      ob_data = bus_b.wb_idata; ob_pend = int'(u_thr.pending);
      @(posedge i_clk); #1;
   endtask

   task automatic wr_a(input logic [29:0] addr, input logic [31:0] wd, input logic [3:0] sel);
      step_a(1'b0, 1'b1, 1'b1, 1'b1, addr, sel, wd);
   endtask
   task automatic rd_a(input logic [29:0] addr);
      step_a(1'b0, 1'b1, 1'b1, 1'b0, addr, 4'hF, 32'h0);
   endtask
   task automatic idle_a();
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
   endtask

   task automatic test_reset();
      bus_b.wb_cyc = 1'b0; bus_b.wb_stb = 1'b0; bus_b.wb_we = 1'b0;
      bus_b.wb_addr = '0; bus_b.wb_sel = '0; bus_b.wb_odata = '0;
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
      step_a(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
      tests++; if (oa_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", oa_ack); end
      tests++; if (oa_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", oa_err); end
      tests++; if (oa_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", oa_stall); end
      tests++; if (oa_data !== 32'h0) begin fails++; $display("FAIL rst_idata: got %h want 0", oa_data); end
      tests++; if (oa_pend != 0) begin fails++; $display("FAIL rst_pending: got %0d want 0", oa_pend); end
      tests++; if (int'(u_thr.pending) != 0 || bus_b.wb_stall !== 1'b0) begin
         fails++; $display("FAIL rst_thr: pending %0d stall %b want 0 0", u_thr.pending, bus_b.wb_stall);
      end
   endtask

   task automatic test_write_read();
      wr_a(30'd5, 32'hDEADBEEF, 4'hF);
      tests++; if (oa_ack !== 1'b0 || oa_stall !== 1'b0) begin fails++; $display("FAIL wr_c0: ack %b stall %b want 0 0", oa_ack, oa_stall); end
      rd_a(30'd5);
      tests++; if (oa_ack !== 1'b0) begin fails++; $display("FAIL wr_c1_ack: got %b want 0", oa_ack); end
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_err !== 1'b0) begin fails++; $display("FAIL wr_ack_lat: ack %b err %b want 1 0", oa_ack, oa_err); end
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: ack %b data %h want 1 deadbeef", oa_ack, oa_data); end
      idle_a();
      tests++; if (oa_ack !== 1'b0 || oa_data !== 32'h0) begin fails++; $display("FAIL rd_after: ack %b data %h want 0 0", oa_ack, oa_data); end
   endtask

   task automatic test_byte_lanes();
      wr_a(30'd5, 32'h11223344, 4'b0101);
      rd_a(30'd5);
      idle_a();
      tests++; if (oa_ack !== 1'b1) begin fails++; $display("FAIL lane_wr_ack: got %b want 1", oa_ack); end
      idle_a();
      tests++; if (oa_data !== 32'hDE22BE44) begin fails++; $display("FAIL lane_data: got %h want de22be44", oa_data); end
      wr_a(30'd5, 32'hFFFFFFFF, 4'b0000);
      rd_a(30'd5);
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_err !== 1'b0) begin fails++; $display("FAIL sel0_ack: ack %b err %b want 1 0", oa_ack, oa_err); end
      idle_a();
      tests++; if (oa_data !== 32'hDE22BE44) begin fails++; $display("FAIL sel0_data: got %h want de22be44", oa_data); end
   endtask

   task automatic test_out_of_range();
      wr_a(30'd0, 32'h0A0B0C0D, 4'hF);
      rd_a(30'd4096);
      idle_a();
      idle_a();
      tests++; if (oa_err !== 1'b1 || oa_ack !== 1'b0 || oa_data !== 32'h0) begin
         fails++; $display("FAIL oor_read: err %b ack %b data %h want 1 0 0", oa_err, oa_ack, oa_data);
      end
      wr_a(30'd4096, 32'hFFFFFFFF, 4'hF);
      rd_a(30'd0);
      idle_a();
      tests++; if (oa_err !== 1'b1 || oa_ack !== 1'b0) begin fails++; $display("FAIL oor_write: err %b ack %b want 1 0", oa_err, oa_ack); end
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_data !== 32'h0A0B0C0D) begin fails++; $display("FAIL oor_addr0: ack %b data %h want 1 0a0b0c0d", oa_ack, oa_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got [3];
      int          stalls = 0;
      int          k = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 6 && (i % 2) == 0) wr_a(30'd9, 32'(i / 2 + 1), 4'hF);
         else if (i < 6)            rd_a(30'd9);
         else                       idle_a();
         if (oa_stall) stalls++;
         if (i >= 3 && (i % 2) == 1 && k < 3) begin got[k] = oa_ack ? oa_data : 32'hFFFFFFFF; k++; end
      end
      tests++; if (stalls != 0) begin fails++; $display("FAIL b2b_stall: %0d stalled cycles want 0", stalls); end
      tests++; if (got[0] !== 32'd1) begin fails++; $display("FAIL b2b_rd0: got %h want 1", got[0]); end
      tests++; if (got[1] !== 32'd2) begin fails++; $display("FAIL b2b_rd1: got %h want 2", got[1]); end
      tests++; if (got[2] !== 32'd3) begin fails++; $display("FAIL b2b_rd2: got %h want 3", got[2]); end
   endtask

   task automatic test_abort();
      rd_a(30'd5);
      rd_a(30'd9);
      step_a(1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
      tests++; if (oa_ack !== 1'b0) begin fails++; $display("FAIL abort_drop0: ack %b want 0", oa_ack); end
      rd_a(30'd5);
      tests++; if (oa_ack !== 1'b0 || oa_err !== 1'b0) begin fails++; $display("FAIL abort_drop1: ack %b err %b want 0 0", oa_ack, oa_err); end
      tests++; if (oa_stall !== 1'b0 || oa_pend != 0) begin fails++; $display("FAIL abort_clear: stall %b pending %0d want 0 0", oa_stall, oa_pend); end
      idle_a();
      tests++; if (oa_ack !== 1'b0) begin fails++; $display("FAIL abort_early: ack %b want 0", oa_ack); end
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_data !== 32'hDE22BE44) begin fails++; $display("FAIL abort_next: ack %b data %h want 1 de22be44", oa_ack, oa_data); end
   endtask

   task automatic test_reset_mid_burst();
      wr_a(30'd20, 32'hCAFEF00D, 4'hF);
      idle_a();
      idle_a();
      rd_a(30'd5);
      rd_a(30'd9);
      step_a(1'b1, 1'b1, 1'b1, 1'b1, 30'd20, 4'hF, 32'h00000055);
      idle_a();
      tests++; if (oa_ack !== 1'b0 || oa_err !== 1'b0 || oa_stall !== 1'b0 || oa_data !== 32'h0) begin
         fails++; $display("FAIL mid_rst_out: ack %b err %b stall %b data %h want all 0", oa_ack, oa_err, oa_stall, oa_data);
      end
      tests++; if (oa_pend != 0) begin fails++; $display("FAIL mid_rst_pend: got %0d want 0", oa_pend); end
      idle_a();
      tests++; if (oa_ack !== 1'b0 || oa_err !== 1'b0) begin fails++; $display("FAIL mid_rst_stray: ack %b err %b want 0 0", oa_ack, oa_err); end
      rd_a(30'd20);
      idle_a();
      idle_a();
      tests++; if (oa_ack !== 1'b1 || oa_data !== 32'hCAFEF00D) begin fails++; $display("FAIL mid_rst_nowrite: ack %b data %h want 1 cafef00d", oa_ack, oa_data); end
   endtask

   task automatic test_stall_throttle();
      int acc = 0, acks = 0, errs = 0, bad = 0, max_pend = 0, first_stall = -1, last_ack = -1;
      for (int n = 0; n < 60 && acc < 8; n++) begin
         step_b(1'b1, 1'b1, 1'b1, 30'(acc), 32'h0B000000 | 32'(acc));
         if (!ob_stall) acc++;
      end
      for (int n = 0; n < 8; n++) step_b(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
      acc = 0;
      for (int n = 0; n < 60 && acks < 8; n++) begin
         step_b(1'b1, acc < 8, 1'b0, 30'(acc), 32'h0);
         if (ob_ack) begin
            if (ob_data !== (32'h0B000000 | 32'(acks))) bad++;
            acks++;
            last_ack = n;
         end
         if (ob_err) errs++;
         if (ob_pend > max_pend) max_pend = ob_pend;
         if (ob_stall && first_stall < 0) first_stall = acc;
         if (acc < 8 && !ob_stall) acc++;
      end
      tests++; if (acks != 8) begin fails++; $display("FAIL thr_acks: got %0d want 8", acks); end
      tests++; if (acc != 8) begin fails++; $display("FAIL thr_accepts: got %0d want 8", acc); end
      tests++; if (bad != 0 || errs != 0) begin fails++; $display("FAIL thr_order: %0d bad data %0d errs want 0 0", bad, errs); end
      tests++; if (first_stall != 2) begin fails++; $display("FAIL thr_stall_rise: after %0d accepts want 2", first_stall); end
      tests++; if (max_pend != 2) begin fails++; $display("FAIL thr_max_pend: got %0d want 2", max_pend); end
      tests++; if (last_ack != 17) begin fails++; $display("FAIL thr_last_ack: cycle %0d want 17", last_ack); end
   endtask

   initial begin
      i_reset = 1'b1;
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      test_abort();
      test_reset_mid_burst();
      test_stall_throttle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
